// File: rtl/puf_challenge_ctrl.sv
// UART-to-PUF challenge/response controller: byte-wise challenge assembly, preset/settle
// launch sequencing, optional majority voting over EVALS runs, LS-byte-first response output.
// Optional RX inter-byte timeout is enabled by defining PUF_RX_TIMEOUT_EN.
module puf_challenge_ctrl #(
  parameter int unsigned CHAL_BYTES     = 8,
  parameter int unsigned RESP_BYTES     = 8,
  parameter int unsigned PRESET_CYCLES  = 65536,
  parameter int unsigned SETTLE_CYCLES  = 65536,
  parameter int unsigned EVALS          = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_byte,
  output logic [8*CHAL_BYTES-1:0] puf_challenge,
  output logic                    puf_launch,
  input  logic [8*RESP_BYTES-1:0] puf_response,
  output logic                    busy,
  output logic                    rx_drop,
  output logic                    frame_err
);

  localparam int unsigned ChalW = 8 * CHAL_BYTES;
  localparam int unsigned RespW = 8 * RESP_BYTES;
  localparam int unsigned CntW  = $clog2(EVALS + 1);
  localparam logic [CntW-1:0] Half = CntW'(EVALS / 2);

  typedef enum logic [2:0] {StIdle, StRecv, StPreset, StEval, StVote, StSend} state_e;

  state_e            state_q, state_d;
  logic              rx_prev_q;
  logic [ChalW-1:0]  chal_sr_q, chal_q;
  logic [ChalW+7:0]  chal_shift;
  logic [4:0]        byte_cnt_q;
  logic [31:0]       timer_q;
  logic [3:0]        eval_cnt_q;
  logic [CntW-1:0]   vote_cnt_q [RespW];
  logic [RespW-1:0]  vote_bits;
  logic [RespW-1:0]  resp_sr_q;
  logic [4:0]        byte_idx_q;
  logic              rx_drop_q;

  logic rx_edge, in_rx, last_byte, preset_done, eval_done, more_evals;
  logic tx_fire, last_tx, timeout;

  assign rx_edge     = rx_valid & ~rx_prev_q;
  assign in_rx       = (state_q == StIdle) || (state_q == StRecv);
  assign chal_shift  = {chal_sr_q, rx_byte};
  assign last_byte   = rx_edge && in_rx && (32'(byte_cnt_q) == CHAL_BYTES - 1);
  assign preset_done = (state_q == StPreset) && (timer_q == PRESET_CYCLES - 1);
  assign eval_done   = (state_q == StEval) && (timer_q == SETTLE_CYCLES - 1);
  assign more_evals  = (32'(eval_cnt_q) + 32'd1) < EVALS;
  assign tx_fire     = (state_q == StSend) && tx_ready;
  assign last_tx     = tx_fire && (32'(byte_idx_q) == RESP_BYTES - 1);

`ifdef PUF_RX_TIMEOUT_EN
  logic [31:0] idle_cnt_q;
  logic        frame_err_q;

  assign timeout   = (state_q == StRecv) && !rx_edge && (idle_cnt_q == TIMEOUT_CYCLES - 1);
  assign frame_err = frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= timeout;
      if ((state_q == StRecv) && !rx_edge && !timeout) idle_cnt_q <= idle_cnt_q + 32'd1;
      else                                             idle_cnt_q <= '0;
    end
  end
`else
  assign timeout   = 1'b0;
  assign frame_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRecv: begin
        if (last_byte)    state_d = StPreset;
        else if (timeout) state_d = StIdle;
        else if (rx_edge) state_d = StRecv;
      end
      StPreset: if (preset_done) state_d = StEval;
      StEval:   if (eval_done) state_d = more_evals ? StPreset : StVote;
      StVote:   state_d = StSend;
      StSend:   if (last_tx) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int b = 0; b < RespW; b++) vote_bits[b] = vote_cnt_q[b] > Half;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_q  <= 1'b0;
      chal_sr_q  <= '0;
      chal_q     <= '0;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      eval_cnt_q <= '0;
      resp_sr_q  <= '0;
      byte_idx_q <= '0;
      rx_drop_q  <= 1'b0;
    end else begin
      rx_prev_q <= rx_valid;
      rx_drop_q <= rx_edge && !in_rx;
      // Timer restarts on every state change so PRESET and EVAL each count from zero.
      if ((state_d == state_q) && ((state_q == StPreset) || (state_q == StEval))) begin
        timer_q <= timer_q + 32'd1;
      end else begin
        timer_q <= '0;
      end
      if (rx_edge && in_rx) begin
        chal_sr_q <= chal_shift[ChalW-1:0];
        if (last_byte) begin
          chal_q     <= chal_shift[ChalW-1:0];
          byte_cnt_q <= '0;
          eval_cnt_q <= '0;
        end else begin
          byte_cnt_q <= byte_cnt_q + 5'd1;
        end
      end else if (timeout) begin
        byte_cnt_q <= '0;
      end
      if (eval_done) eval_cnt_q <= eval_cnt_q + 4'd1;
      if (state_q == StVote) begin
        resp_sr_q  <= vote_bits;
        byte_idx_q <= '0;
      end else if (tx_fire) begin
        resp_sr_q  <= resp_sr_q >> 8;
        byte_idx_q <= byte_idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < RespW; b++) vote_cnt_q[b] <= '0;
    end else if (last_byte) begin
      for (int b = 0; b < RespW; b++) vote_cnt_q[b] <= '0;
    end else if (eval_done) begin
      for (int b = 0; b < RespW; b++) vote_cnt_q[b] <= vote_cnt_q[b] + CntW'(puf_response[b]);
    end
  end

  assign tx_valid      = (state_q == StSend);
  assign tx_byte       = resp_sr_q[7:0];
  assign puf_challenge = chal_q;
  assign puf_launch    = (state_q == StEval);
  assign busy          = (state_q != StIdle);
  assign rx_drop       = rx_drop_q;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Bench for puf_challenge_ctrl: two instances (EVALS=1 and EVALS=3) share all inputs and are
// checked every cycle against a timeline model, plus directed literal scenarios.
module tb_puf_challenge_ctrl;
  localparam int P  = 4;
  localparam int S  = 8;
  localparam int E  = P + S;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_ready = 1'b0;
  logic [63:0] resp_in = '0;

  logic        txv    [2];
  logic [7:0]  txb    [2];
  logic [63:0] chal   [2];
  logic        launch [2];
  logic        busy   [2];
  logic        drop   [2];
  logic        ferr   [2];

  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  int          resp_mode = 1;
  int          ready_mode = 1;
  logic [63:0] resp_const = 64'hA5A5_0000_1234_5678;
  longint      t_edge = 0;
  longint      t_frame = 0;

  puf_challenge_ctrl #(
    .CHAL_BYTES(8), .RESP_BYTES(8), .PRESET_CYCLES(P), .SETTLE_CYCLES(S), .EVALS(1),
    .TIMEOUT_CYCLES(TO)
  ) u_dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_ready(tx_ready),
    .tx_valid(txv[0]), .tx_byte(txb[0]), .puf_challenge(chal[0]), .puf_launch(launch[0]),
    .puf_response(resp_in), .busy(busy[0]), .rx_drop(drop[0]), .frame_err(ferr[0])
  );

  puf_challenge_ctrl #(
    .CHAL_BYTES(8), .RESP_BYTES(8), .PRESET_CYCLES(P), .SETTLE_CYCLES(S), .EVALS(3),
    .TIMEOUT_CYCLES(TO)
  ) u_dut3 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_ready(tx_ready),
    .tx_valid(txv[1]), .tx_byte(txb[1]), .puf_challenge(chal[1]), .puf_launch(launch[1]),
    .puf_response(resp_in), .busy(busy[1]), .rx_drop(drop[1]), .frame_err(ferr[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, i, cyc, act, exp);
    end
  endtask

  // Response and tx_ready drivers.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (resp_mode)
        0:       resp_in = {$urandom, $urandom};
        1:       resp_in = resp_const;
        default: resp_in = (cyc >= t_frame + E + 1 && cyc <= t_frame + 2 * E) ? '0 : '1;
      endcase
      case (ready_mode)
        0:       tx_ready = 1'($urandom_range(0, 1));
        1:       tx_ready = 1'b1;
        2:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Timeline model: each instance is either collecting bytes or running a frame whose phase
  // follows from the distance d to the cycle T of its last challenge byte.
  int          m_ev [2] = '{1, 3};
  bit          m_act [2];
  int          m_nrx [2];
  longint      m_T [2];
  longint      m_last [2];
  logic [63:0] m_sr [2];
  logic [63:0] m_chal [2];
  int          m_cnt [2][64];
  logic [7:0]  m_tx [2][8];
  int          m_txi [2];
  bit          m_drop [2];
  bit          m_ferr [2];
  bit          m_prev = 1'b0;

  always @(negedge clk) begin
    bit     edge_v, e_busy, e_launch, e_txv;
    logic [7:0] e_txb;
    longint d, tot;
    edge_v = rx_valid && !m_prev;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_nrx[i] = 0; m_sr[i] = '0; m_chal[i] = '0; m_txi[i] = 0;
        m_drop[i] = 0; m_ferr[i] = 0;
      end
      tot = longint'(m_ev[i] * E);
      d = cyc - m_T[i];
      e_busy = m_act[i] || (m_nrx[i] > 0);
      e_launch = 0; e_txv = 0; e_txb = 8'h00;
      if (m_act[i]) begin
        if (d <= tot) e_launch = ((d - 1) % E) >= P;
        else if (d >= tot + 2) begin
          e_txv = 1;
          e_txb = m_tx[i][m_txi[i]];
        end
      end
      chk("busy", i, 64'(busy[i]), 64'(e_busy));
      chk("puf_launch", i, 64'(launch[i]), 64'(e_launch));
      chk("tx_valid", i, 64'(txv[i]), 64'(e_txv));
      if (e_txv || rst) chk("tx_byte", i, 64'(txb[i]), 64'(e_txb));
      chk("puf_challenge", i, chal[i], m_chal[i]);
      chk("rx_drop", i, 64'(drop[i]), 64'(m_drop[i]));
      chk("frame_err", i, 64'(ferr[i]), 64'(m_ferr[i]));
      if (!rst) begin
        m_drop[i] = 0;
        m_ferr[i] = 0;
        if (m_act[i]) begin
          if (edge_v) m_drop[i] = 1;
          if (d <= tot && ((d - 1) % E) == E - 1)
            for (int b = 0; b < 64; b++) m_cnt[i][b] += int'(resp_in[b]);
          if (d == tot + 1) begin
            for (int j = 0; j < 8; j++)
              for (int k = 0; k < 8; k++) m_tx[i][j][k] = m_cnt[i][8*j+k] > m_ev[i] / 2;
            m_txi[i] = 0;
          end
          if (d >= tot + 2 && tx_ready) begin
            m_txi[i]++;
            if (m_txi[i] == 8) m_act[i] = 0;
          end
        end else if (edge_v) begin
          m_sr[i] = {m_sr[i][55:0], rx_byte};
          m_nrx[i]++;
          m_last[i] = cyc;
          if (m_nrx[i] == 8) begin
            m_chal[i] = m_sr[i];
            m_act[i] = 1;
            m_T[i] = cyc;
            m_nrx[i] = 0;
            for (int b = 0; b < 64; b++) m_cnt[i][b] = 0;
          end
        end
`ifdef PUF_RX_TIMEOUT_EN
        else if (m_nrx[i] > 0 && cyc - m_last[i] == TO) begin
          m_nrx[i] = 0;
          m_ferr[i] = 1;
        end
`endif
      end
    end
    m_prev = rst ? 1'b0 : rx_valid;
  end

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    t_edge   = cyc;
    repeat (hi) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (lo - 1) @(posedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1]) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_wait", 0, {62'd0, busy[1], busy[0]}, 64'd0);
  endtask

  task automatic frame_fixed(output longint t);
    for (int k = 1; k <= 8; k++) send_byte(8'(k), 1, 1);
    t = t_edge;
    t_frame = t_edge;
  endtask

  int         mon_first [2];
  int         mon_launch [2];
  int         mon_drop [2];
  int         mon_ferr [2];
  int         mon_nacc [2];
  logic       mon_after [2];
  logic [7:0] mon_got [2][8];

  task automatic monitor(input longint t0, input int ncyc);
    bit pend [2];
    for (int i = 0; i < 2; i++) begin
      mon_first[i] = -1; mon_launch[i] = 0; mon_drop[i] = 0; mon_ferr[i] = 0;
      mon_nacc[i] = 0; mon_after[i] = 1'bx; pend[i] = 0;
    end
    repeat (ncyc) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          mon_after[i] = txv[i];
          pend[i] = 0;
        end
        if (launch[i]) mon_launch[i]++;
        if (drop[i]) mon_drop[i]++;
        if (ferr[i]) mon_ferr[i]++;
        if (txv[i] && mon_first[i] < 0) mon_first[i] = int'(cyc - t0);
        if (txv[i] && tx_ready) begin
          if (mon_nacc[i] < 8) mon_got[i][mon_nacc[i]] = txb[i];
          mon_nacc[i]++;
          if (mon_nacc[i] == 8) pend[i] = 1;
        end
      end
    end
  endtask

  logic [7:0] exp_b [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'hA5, 8'hA5};

  initial begin
    longint t;
    int     n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx_valid", i, 64'(txv[i]), 64'd0);
      chk("rst_busy", i, 64'(busy[i]), 64'd0);
      chk("rst_challenge", i, chal[i], 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame, EVALS=1 and EVALS=3 with a constant response.
    resp_mode = 1; ready_mode = 1;
    wait_idle();
    frame_fixed(t);
    monitor(t, 70);
    chk("chal_literal", 0, chal[0], 64'h0102030405060708);
    chk("launch_cycles", 0, 64'(mon_launch[0]), 64'd8);
    chk("launch_cycles", 1, 64'(mon_launch[1]), 64'd24);
    chk("first_tx", 0, 64'(mon_first[0]), 64'd14);
    chk("first_tx", 1, 64'(mon_first[1]), 64'd38);
    chk("n_accept", 0, 64'(mon_nacc[0]), 64'd8);
    for (int k = 0; k < 8; k++) chk("byte_order", 0, 64'(mon_got[0][k]), 64'(exp_b[k]));

    // Ready toggling: same bytes, no duplicates or skips, valid drops after the 8th accept.
    ready_mode = 2;
    wait_idle();
    frame_fixed(t);
    monitor(t, 70);
    chk("n_accept_toggle", 0, 64'(mon_nacc[0]), 64'd8);
    for (int k = 0; k < 8; k++) chk("byte_toggle", 0, 64'(mon_got[0][k]), 64'(exp_b[k]));
    chk("valid_after_last", 0, 64'(mon_after[0]), 64'd0);

    // Majority vote over FF / 00 / FF windows.
    resp_mode = 2; ready_mode = 1;
    wait_idle();
    frame_fixed(t);
    monitor(t, 70);
    chk("first_tx_vote", 1, 64'(mon_first[1]), 64'd38);
    for (int k = 0; k < 8; k++) chk("vote_byte", 1, 64'(mon_got[1][k]), 64'hFF);

    // Stray byte during EVAL is dropped and the response is undisturbed.
    resp_mode = 1;
    wait_idle();
    frame_fixed(t);
    fork
      monitor(t, 70);
      begin
        repeat (4) @(posedge clk);
        send_byte(8'h55, 1, 1);
      end
    join
    chk("drop_count", 0, 64'(mon_drop[0]), 64'd1);
    for (int k = 0; k < 8; k++) chk("byte_after_drop", 0, 64'(mon_got[0][k]), 64'(exp_b[k]));

`ifdef PUF_RX_TIMEOUT_EN
    wait_idle();
    for (int k = 0; k < 3; k++) send_byte(8'(8'hC0 + k), 1, 1);
    monitor(t_edge, 110);
    chk("frame_err_count", 0, 64'(mon_ferr[0]), 64'd1);
    chk("busy_after_timeout", 0, 64'(busy[0]), 64'd0);
    chk("busy_after_timeout", 1, 64'(busy[1]), 64'd0);
`endif

    // Reset in the middle of SEND.
    ready_mode = 3;
    wait_idle();
    frame_fixed(t);
    n = 0;
    while (!txv[0] && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("reach_send", 0, 64'(txv[0]), 64'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_tx_valid", i, 64'(txv[i]), 64'd0);
      chk("midrst_tx_byte", i, 64'(txb[i]), 64'd0);
      chk("midrst_launch", i, 64'(launch[i]), 64'd0);
      chk("midrst_busy", i, 64'(busy[i]), 64'd0);
      chk("midrst_challenge", i, chal[i], 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic, checked cycle by cycle by the model.
    resp_mode = 0; ready_mode = 0;
    for (int f = 0; f < 15; f++) begin
      wait_idle();
      for (int k = 0; k < 8; k++)
        send_byte(8'($urandom), $urandom_range(1, 2), $urandom_range(1, 3));
      t_frame = t_edge;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        send_byte(8'($urandom), 1, 1);
      end
    end
    wait_idle();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
